// File: rtl/sram_arb_2p_pkg.sv
// Shared constants and types for the two-port SRAM arbiter.
package sram_arb_2p_pkg;

  localparam int unsigned SRAM_ADDR_W = 10;
  localparam int unsigned SRAM_DATA_W = 32;

  // FIXED_PRIO encodings
  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  typedef enum logic {
    PortCpu = 1'b0,
    PortDma = 1'b1
  } port_e;

endpackage

// File: rtl/sram_arb_2p_rr_arb2.sv
// Two-way arbiter: round-robin on contention, or port 0 always wins when FIXED_PRIO is set.
module sram_arb_2p_rr_arb2
  import sram_arb_2p_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = PRIO_RR
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  port_e r_last_grant;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        if (FIXED_PRIO == PRIO_FIXED || r_last_grant == PortDma) begin
          gnt_o = 2'b01;
        end else begin
          gnt_o = 2'b10;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

  // Reset to DMA so the CPU wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_grant <= PortDma;
    end else if (adv_i) begin
      r_last_grant <= gnt_o[1] ? PortDma : PortCpu;
    end
  end

endmodule

// File: rtl/sram_arb_2p.sv
// Arbitrates a single-port synchronous SRAM macro between a CPU port and a DMA port;
// responses return with a fixed one-cycle latency on the port that was granted.
module sram_arb_2p
  import sram_arb_2p_pkg::*;
#(
  parameter int unsigned ADDR_W     = SRAM_ADDR_W,
  parameter int unsigned DATA_W     = SRAM_DATA_W,
  parameter int unsigned FIXED_PRIO = PRIO_RR
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                p0_valid_i,
  output logic                p0_ready_o,
  input  logic                p0_we_i,
  input  logic [ADDR_W-1:0]   p0_addr_i,
  input  logic [DATA_W-1:0]   p0_wdata_i,
  input  logic [DATA_W/8-1:0] p0_wstrb_i,
  output logic                p0_rvalid_o,
  output logic [DATA_W-1:0]   p0_rdata_o,

  input  logic                p1_valid_i,
  output logic                p1_ready_o,
  input  logic                p1_we_i,
  input  logic [ADDR_W-1:0]   p1_addr_i,
  input  logic [DATA_W-1:0]   p1_wdata_i,
  input  logic [DATA_W/8-1:0] p1_wstrb_i,
  output logic                p1_rvalid_o,
  output logic [DATA_W-1:0]   p1_rdata_o,

  output logic                sram_cs_o,
  output logic                sram_wren_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_data_o,
  output logic [DATA_W/8-1:0] sram_mask_o,
  input  logic [DATA_W-1:0]   sram_data_i
);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_rsp_vld;
  logic [DATA_W-1:0] w_rsp_data;

  logic  r_rsp_pend;
  port_e r_rsp_port;
  logic  r_rsp_we;

  // Requests are masked during reset so nothing reaches the macro that cycle.
  assign w_req = rst_i ? 2'b00 : {p1_valid_i, p0_valid_i};

  sram_arb_2p_rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (w_req),
    .adv_i (|w_gnt),
    .gnt_o (w_gnt)
  );

  assign p0_ready_o = w_gnt[0];
  assign p1_ready_o = w_gnt[1];

  always_comb begin
    sram_cs_o   = 1'b0;
    sram_wren_o = 1'b0;
    sram_addr_o = '0;
    sram_data_o = '0;
    sram_mask_o = '0;
    if (w_gnt[0]) begin
      sram_cs_o   = 1'b1;
      sram_wren_o = p0_we_i;
      sram_addr_o = p0_addr_i;
      sram_data_o = p0_wdata_i;
      sram_mask_o = p0_wstrb_i;
    end else if (w_gnt[1]) begin
      sram_cs_o   = 1'b1;
      sram_wren_o = p1_we_i;
      sram_addr_o = p1_addr_i;
      sram_data_o = p1_wdata_i;
      sram_mask_o = p1_wstrb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_pend <= 1'b0;
      r_rsp_port <= PortCpu;
      r_rsp_we   <= 1'b0;
    end else begin
      r_rsp_pend <= |w_gnt;
      r_rsp_port <= w_gnt[1] ? PortDma : PortCpu;
      r_rsp_we   <= sram_wren_o;
    end
  end

  // A response still pending when reset rises is dropped, not delivered.
  assign w_rsp_vld  = r_rsp_pend & ~rst_i;
  assign w_rsp_data = r_rsp_we ? '0 : sram_data_i;

  always_comb begin
    p0_rvalid_o = 1'b0;
    p0_rdata_o  = '0;
    p1_rvalid_o = 1'b0;
    p1_rdata_o  = '0;
    if (w_rsp_vld) begin
      if (r_rsp_port == PortCpu) begin
        p0_rvalid_o = 1'b1;
        p0_rdata_o  = w_rsp_data;
      end else begin
        p1_rvalid_o = 1'b1;
        p1_rdata_o  = w_rsp_data;
      end
    end
  end

endmodule
